// File: rtl/qpsk_demap_packer.sv
// QPSK hard-decision demapper: Gray-coded 2-bit symbols packed MSB-first into
// OUT_WIDTH-bit words, buffered in a word FIFO behind a registered valid/ready port.
module qpsk_demap_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sym_valid,
  input  logic [DATA_WIDTH-1:0] I_sym,
  input  logic [DATA_WIDTH-1:0] Q_sym,
  input  logic                  sync_clear,
  input  logic                  clear_ovf,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  overflow
);

  localparam int SYMS  = OUT_WIDTH / 2;
  localparam int PH_W  = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(SYMS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Sign-bit decision: negative maps to 1, zero and positive map to 0.
  function automatic logic [1:0] demap(input logic [DATA_WIDTH-1:0] i_v,
                                       input logic [DATA_WIDTH-1:0] q_v);
    return {i_v[DATA_WIDTH-1], q_v[DATA_WIDTH-1]};
  endfunction

  logic [PH_W-1:0]      phase_r;
  logic [OUT_WIDTH-1:0] sr_r;
  logic [OUT_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 ovf_r;
  logic                 out_valid_r;
  logic [OUT_WIDTH-1:0] out_data_r;

  logic [1:0]           code_s;
  logic [OUT_WIDTH-1:0] word_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 accept_s;
  logic                 drop_s;
  logic [PTR_W-1:0]     rd_next_s;

  // Word completion, FIFO handshake and drop decisions.
  always_comb begin
    code_s    = demap(I_sym, Q_sym);
    word_s    = {sr_r[OUT_WIDTH-3:0], code_s};
    push_s    = sym_valid & ~sync_clear & (phase_r == LAST_PH);
    pop_s     = out_valid_r & out_ready;
    full_s    = (count_r == FULL_CNT);
    accept_s  = push_s & (~full_s | pop_s);
    drop_s    = push_s & full_s & ~pop_s;
    rd_next_s = rd_ptr_r + PTR_W'(1);
  end

  // Symbol packer: phase counter and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r <= '0;
      sr_r    <= '0;
    end else if (sync_clear) begin
      if (sym_valid) begin
        phase_r <= PH_W'(1);
        sr_r    <= {{(OUT_WIDTH-2){1'b0}}, code_s};
      end else begin
        phase_r <= '0;
        sr_r    <= '0;
      end
    end else if (sym_valid) begin
      if (phase_r == LAST_PH) begin
        phase_r <= '0;
        sr_r    <= '0;
      end else begin
        phase_r <= phase_r + PH_W'(1);
        sr_r    <= word_s;
      end
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= word_s;
    end
  end

  // FIFO pointers, occupancy and sticky overflow (a drop beats clear_ovf).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ovf_r    <= 1'b0;
    end else begin
      if (accept_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)    rd_ptr_r <= rd_next_s;
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s)         ovf_r <= 1'b1;
      else if (clear_ovf) ovf_r <= 1'b0;
    end
  end

  // Registered head: only words already in storage are presented, so a fresh
  // word into an empty FIFO shows one edge after it was written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (pop_s) begin
      if (count_r > CNT_W'(1)) begin
        out_valid_r <= 1'b1;
        out_data_r  <= mem_r[rd_next_s];
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (!out_valid_r && (count_r != '0)) begin
      out_valid_r <= 1'b1;
      out_data_r  <= mem_r[rd_ptr_r];
    end
  end

  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign fifo_count = count_r;
  assign overflow   = ovf_r;

endmodule
